// File: rtl/traffic_phase_sequencer.sv
// rtl/traffic_phase_sequencer.sv - two-approach traffic-light phase sequencer with ped service and night flash
module traffic_phase_sequencer #(
   parameter int TICK_DIV = 25_000_000,
   parameter int GREEN_T  = 10,
   parameter int YELLOW_T = 3,
   parameter int ALLRED_T = 1,
   parameter int WALK_T   = 5,
   parameter int PED_MIN  = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ped_req,
   input  logic       night_mode,
   output logic [2:0] ns_lamp,
   output logic [2:0] ew_lamp,
   output logic       ped_walk,
   output logic [2:0] phase,
   output logic [3:0] sec_left
);

   localparam int CW = $clog2(TICK_DIV);

   typedef enum logic [2:0] {
      NS_GREEN  = 3'd0,
      NS_YELLOW = 3'd1,
      ALL_RED_1 = 3'd2,
      EW_GREEN  = 3'd3,
      EW_YELLOW = 3'd4,
      ALL_RED_2 = 3'd5,
      FLASH     = 3'd6
   } phase_e;

   localparam logic [2:0] LAMP_R   = 3'b100;
   localparam logic [2:0] LAMP_Y   = 3'b010;
   localparam logic [2:0] LAMP_G   = 3'b001;

   logic [CW-1:0] cnt_q;
   logic          tick;
   phase_e        phase_q, phase_d;
   logic [3:0]    sec_q, sec_d;
   logic          ped_q, ped_d;
   logic          walk_q, walk_d;
   logic          flash_q, flash_d;

   function automatic phase_e next_phase(input phase_e p);
      case (p)
         ALL_RED_2: next_phase = NS_GREEN;
         NS_GREEN:  next_phase = NS_YELLOW;
         NS_YELLOW: next_phase = ALL_RED_1;
         ALL_RED_1: next_phase = EW_GREEN;
         EW_GREEN:  next_phase = EW_YELLOW;
         default:   next_phase = ALL_RED_2;
      endcase
   endfunction

   function automatic logic [3:0] duration(input phase_e p);
      case (p)
         NS_GREEN, EW_GREEN:   duration = 4'(GREEN_T);
         NS_YELLOW, EW_YELLOW: duration = 4'(YELLOW_T);
         default:              duration = 4'(ALLRED_T);
      endcase
   endfunction

   assign tick = (cnt_q == CW'(TICK_DIV - 1));

   // Free-running tick prescaler; restarted only when leaving night flash
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if ((phase_q == FLASH && !night_mode) || tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   // Phase, countdown, pedestrian latch, walk flag and flash phase registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= ALL_RED_2;
         sec_q   <= 4'(ALLRED_T);
         ped_q   <= 1'b0;
         walk_q  <= 1'b0;
         flash_q <= 1'b0;
      end else begin
         phase_q <= phase_d;
         sec_q   <= sec_d;
         ped_q   <= ped_d;
         walk_q  <= walk_d;
         flash_q <= flash_d;
      end
   end

   // Next-state: night override, flash exit, timer advance, then green truncation
   always_comb begin
      phase_d = phase_q;
      sec_d   = sec_q;
      ped_d   = ped_q | ped_req;
      walk_d  = walk_q;
      flash_d = flash_q;
      if (night_mode) begin
         phase_d = FLASH;
         sec_d   = 4'd0;
         ped_d   = 1'b0;
         walk_d  = 1'b0;
         if (phase_q != FLASH) begin
            flash_d = 1'b0;
         end else if (tick) begin
            flash_d = ~flash_q;
         end
      end else if (phase_q == FLASH) begin
         phase_d = ALL_RED_2;
         sec_d   = 4'(ALLRED_T);
         ped_d   = 1'b0;
         walk_d  = 1'b0;
         flash_d = 1'b0;
      end else if (tick) begin
         if (sec_q > 4'd1) begin
            sec_d = sec_q - 4'd1;
         end else begin
            phase_d = next_phase(phase_q);
            walk_d  = 1'b0;
            sec_d   = duration(next_phase(phase_q));
            if (next_phase(phase_q) == ALL_RED_1 || next_phase(phase_q) == ALL_RED_2) begin
               // Entering all-red consumes the pending request; clear beats a same-cycle set
               ped_d  = 1'b0;
               walk_d = ped_q;
               if (ped_q) begin
                  sec_d = 4'(WALK_T);
               end
            end
         end
      end else if ((phase_q == NS_GREEN || phase_q == EW_GREEN) && ped_q &&
                   (sec_q > 4'(PED_MIN))) begin
         sec_d = 4'(PED_MIN);
      end
   end

   // Moore lamp and status decode from registered state
   always_comb begin
      ns_lamp  = LAMP_R;
      ew_lamp  = LAMP_R;
      ped_walk = walk_q;
      phase    = phase_q;
      sec_left = sec_q;
      case (phase_q)
         NS_GREEN:  ns_lamp = LAMP_G;
         NS_YELLOW: ns_lamp = LAMP_Y;
         EW_GREEN:  ew_lamp = LAMP_G;
         EW_YELLOW: ew_lamp = LAMP_Y;
         FLASH: begin
            ns_lamp  = {1'b0, flash_q, 1'b0};
            ew_lamp  = {flash_q, 2'b00};
            ped_walk = 1'b0;
         end
         default: ;
      endcase
   end

endmodule
